grid_cursor_ctrl: RTL
=====================

// Module: grid_cursor_ctrl
// PURPOSE
//   Parametrised successor to the board cursor/operation logic. Turns debounced
//   button levels into a registered (x,y) cursor over a ROWS x COLS board, a
//   1-cycle eliminate pulse and a 1-cycle moved pulse. Adds edge detection,
//   hold-to-repeat, clamp/wrap edge mode and a busy lock-out. Sits between the
//   button debouncers and the board/elimination logic.
// PARAMETERS
//   ROWS          8           board rows; x range 0..ROWS-1 (up/down move x)
//   COLS          8           board columns; y range 0..COLS-1 (left/right move y)
//   X_W           4           width of cur_x; must satisfy 2**X_W >= ROWS
//   Y_W           4           width of cur_y; must satisfy 2**Y_W >= COLS
//   WRAP          0           0 = clamp at the board edge; 1 = wrap to the opposite edge
//   INIT_X        0           cur_x value after reset
//   INIT_Y        0           cur_y value after reset
//   REPEAT_DELAY  25_000_000  cycles a direction is held before the first repeat
//   REPEAT_RATE   5_000_000   cycles between repeats after the first one
// PORTS
//   clk        in   1    system clock
//   rst        in   1    synchronous reset, active-high
//   operation  in   5    button levels: [0] confirm, [1] left (y-1), [2] right (y+1),
//                        [3] up (x-1), [4] down (x+1)
//   busy       in   1    elimination or animation in progress; blocks all actions
//   cur_x      out  X_W  cursor row, registered
//   cur_y      out  Y_W  cursor column, registered
//   eliminate  out  1    1-cycle pulse; confirm accepted at (cur_x,cur_y)
//   moved      out  1    1-cycle pulse; cursor position changed this cycle
// BEHAVIOUR
//   - Reset values: cur_x=INIT_X, cur_y=INIT_Y, eliminate=0, moved=0, FSM=IDLE,
//     repeat counter=0, op_q=5'b11111. A button held through reset therefore
//     does not fire.
//   - Edges: op_q <= operation every cycle, busy included. press = operation & ~op_q.
//   - Latency: an action lands on the same edge that samples the press. Outputs
//     show the result one cycle after the input rises.
//   - Priority, one action per cycle: confirm > up > down > left > right.
//     Presses that lose arbitration are dropped. They are not queued.
//   - Confirm: eliminate=1 for exactly 1 cycle; cursor unchanged. Confirm never
//     repeats.
//   - Step: decrement or increment the target axis.
//       WRAP=0: a step at the edge leaves the axis unchanged and moved=0.
//       WRAP=1: 0-1 goes to max, max+1 goes to 0, and moved=1.
//     Arithmetic is done at X_W/Y_W bits against ROWS-1/COLS-1, never against 2**W-1.
//   - busy=1: no step, no eliminate, FSM forced to IDLE, counter cleared. When
//     busy falls, a level that is still held does not act; only a new edge acts.
//   - Repeat FSM: IDLE -> DELAY -> REPEAT.
//       IDLE: an accepted direction press records dir and goes to DELAY, counter=0.
//       DELAY: the counter runs while operation[dir] is held. At REPEAT_DELAY-1:
//         step, counter=0, go to REPEAT.
//       REPEAT: at REPEAT_RATE-1: step, counter=0.
//       DELAY/REPEAT exit: release of operation[dir] -> IDLE. A new accepted
//         direction press restarts DELAY with the new dir.
//       Confirm does not disturb the FSM.
//   - Simultaneous release of dir and counter expiry: release wins, no step.
// CONFIGURATION
//   GRID_CURSOR_AUTOREPEAT_EN
//     defined: repeat FSM and counter present, as described above.
//     undefined: no counter or FSM. Each press edge gives exactly one step;
//     REPEAT_* parameters are ignored.
// STRUCTURE
//   grid_cursor_pkg: OP_CONFIRM/OP_LEFT/OP_RIGHT/OP_UP/OP_DOWN bit indices,
//     rpt_state_t enum {RPT_IDLE, RPT_DELAY, RPT_REPEAT}.
//   Sub-module grid_cursor_repeat_timer: FSM plus counter; outputs a 1-cycle
//     repeat_step and the held dir. Instantiated only under the macro.
// TESTING  (ROWS=5, COLS=6, REPEAT_DELAY=4, REPEAT_RATE=2, macro defined unless noted)
//   1. Reset with operation=5'b10000 held, then release -> cur=(0,0), no moved
//      pulse at any point.
//   2. WRAP=0, cursor (4,5): pulse down, then right -> stays (4,5), moved=0.
//      WRAP=1: same input -> (0,5), then (0,0), moved=1 each time.
//   3. Hold right from (0,0) for 12 cycles -> steps at cycles 1, 5, 7, 9, 11;
//      cur_y=5 at the end with WRAP=0.
//   4. Press confirm and up in the same cycle at (2,2) -> eliminate=1 for 1 cycle,
//      cursor stays (2,2).
//   5. busy=1 while confirm rises, busy falls with confirm still held ->
//      eliminate never asserted; a new press after release fires once.
//   6. Macro undefined: hold down for 20 cycles from (0,0) -> exactly one step
//      to (1,0).

Source files
------------

// File: rtl/grid_cursor_pkg.sv
// grid_cursor_pkg: shared definitions for the grid cursor controller.
//   OP_* : bit indices into the 5-bit operation button vector.
//   rpt_state_t : states of the hold-to-repeat FSM.
package grid_cursor_pkg;

  localparam int OP_W = 5;

  typedef logic [2:0] op_idx_t;

  localparam op_idx_t OP_CONFIRM = 3'd0;
  localparam op_idx_t OP_LEFT    = 3'd1;  // y - 1
  localparam op_idx_t OP_RIGHT   = 3'd2;  // y + 1
  localparam op_idx_t OP_UP      = 3'd3;  // x - 1
  localparam op_idx_t OP_DOWN    = 3'd4;  // x + 1

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } rpt_state_t;

endpackage

// File: rtl/grid_cursor_repeat_timer.sv
// grid_cursor_repeat_timer: hold-to-repeat FSM and counter.
//   clk, rst     : clock, synchronous active-high reset
//   busy         : forces the FSM to IDLE and clears the counter
//   start        : an accepted direction press this cycle
//   start_dir    : operation bit index of that press
//   operation    : raw button levels, used to see whether dir is still held
//   repeat_step  : 1-cycle request for one more step in direction dir
//   dir          : direction currently being tracked
module grid_cursor_repeat_timer
  import grid_cursor_pkg::*;
#(
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            busy,
  input  logic            start,
  input  op_idx_t         start_dir,
  input  logic [OP_W-1:0] operation,
  output logic            repeat_step,
  output op_idx_t         dir
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  rpt_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  op_idx_t          dir_q, dir_nxt;
  logic             held;

  assign held = operation[dir_q];
  assign dir  = dir_q;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    dir_nxt     = dir_q;
    repeat_step = 1'b0;
    if (busy) begin
      state_nxt = RPT_IDLE;
      cnt_nxt   = '0;
    end else if (start) begin
      state_nxt = RPT_DELAY;
      cnt_nxt   = '0;
      dir_nxt   = start_dir;
    end else begin
      unique case (state)
        RPT_IDLE: ;
        // Release is checked before expiry so a release on the expiry cycle
        // never produces a step.
        RPT_DELAY: begin
          if (!held) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == DELAY_LAST) begin
            repeat_step = 1'b1;
            cnt_nxt     = '0;
            state_nxt   = RPT_REPEAT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        RPT_REPEAT: begin
          if (!held) begin
            state_nxt = RPT_IDLE;
            cnt_nxt   = '0;
          end else if (cnt == RATE_LAST) begin
            repeat_step = 1'b1;
            cnt_nxt     = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RPT_IDLE;
      cnt   <= '0;
      dir_q <= OP_UP;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      dir_q <= dir_nxt;
    end
  end

endmodule

// File: rtl/grid_cursor_ctrl.sv
// grid_cursor_ctrl: turns debounced button levels into a registered (x,y)
// cursor over a ROWS x COLS board plus 1-cycle eliminate and moved pulses.
//   clk, rst   : clock, synchronous active-high reset
//   operation  : [0] confirm, [1] left, [2] right, [3] up, [4] down (levels)
//   busy       : blocks every action and cancels any hold-to-repeat
//   cur_x      : cursor row (up/down), cur_y : cursor column (left/right)
//   eliminate  : confirm accepted at (cur_x,cur_y)
//   moved      : cursor position changed on this edge
// Build option: define GRID_CURSOR_AUTOREPEAT_EN to add hold-to-repeat;
// without it each press edge gives exactly one step.
module grid_cursor_ctrl
  import grid_cursor_pkg::*;
#(
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int X_W          = 4,
  parameter int Y_W          = 4,
  parameter int WRAP         = 0,
  parameter int INIT_X       = 0,
  parameter int INIT_Y       = 0,
  parameter int REPEAT_DELAY = 25_000_000,
  parameter int REPEAT_RATE  = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] operation,
  input  logic            busy,
  output logic [X_W-1:0]  cur_x,
  output logic [Y_W-1:0]  cur_y,
  output logic            eliminate,
  output logic            moved
);

  localparam logic [X_W-1:0] X_MAX = X_W'(ROWS - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(COLS - 1);

  logic [OP_W-1:0] op_q;
  logic [OP_W-1:0] press;
  logic            act_elim;
  logic            act_step;
  op_idx_t         act_dir;
  logic            start;
  logic            repeat_step;
  op_idx_t         rpt_dir;
  logic [X_W-1:0]  nxt_x;
  logic [Y_W-1:0]  nxt_y;

  assign press = operation & ~op_q;

  // One action per cycle: confirm > up > down > left > right > repeat.
  // Losing presses are simply dropped.
  always_comb begin
    act_elim = 1'b0;
    act_step = 1'b0;
    act_dir  = OP_UP;
    start    = 1'b0;
    if (!busy) begin
      if (press[OP_CONFIRM]) begin
        act_elim = 1'b1;
      end else if (press[OP_UP]) begin
        act_step = 1'b1; act_dir = OP_UP;    start = 1'b1;
      end else if (press[OP_DOWN]) begin
        act_step = 1'b1; act_dir = OP_DOWN;  start = 1'b1;
      end else if (press[OP_LEFT]) begin
        act_step = 1'b1; act_dir = OP_LEFT;  start = 1'b1;
      end else if (press[OP_RIGHT]) begin
        act_step = 1'b1; act_dir = OP_RIGHT; start = 1'b1;
      end else if (repeat_step) begin
        act_step = 1'b1; act_dir = rpt_dir;
      end
    end
  end

`ifdef GRID_CURSOR_AUTOREPEAT_EN
  grid_cursor_repeat_timer #(
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) u_repeat_timer (
    .clk         (clk),
    .rst         (rst),
    .busy        (busy),
    .start       (start),
    .start_dir   (act_dir),
    .operation   (operation),
    .repeat_step (repeat_step),
    .dir         (rpt_dir)
  );
`else
  logic unused_rpt;
  assign unused_rpt  = ^{start, 32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
  assign repeat_step = 1'b0;
  assign rpt_dir     = OP_UP;
`endif

  // Edge limits are ROWS-1/COLS-1, not the all-ones value of the register.
  always_comb begin
    nxt_x = cur_x;
    nxt_y = cur_y;
    if (act_step) begin
      unique case (act_dir)
        OP_UP:    nxt_x = (cur_x == '0)    ? ((WRAP != 0) ? X_MAX : cur_x) : cur_x - X_W'(1);
        OP_DOWN:  nxt_x = (cur_x >= X_MAX) ? ((WRAP != 0) ? '0    : cur_x) : cur_x + X_W'(1);
        OP_LEFT:  nxt_y = (cur_y == '0)    ? ((WRAP != 0) ? Y_MAX : cur_y) : cur_y - Y_W'(1);
        OP_RIGHT: nxt_y = (cur_y >= Y_MAX) ? ((WRAP != 0) ? '0    : cur_y) : cur_y + Y_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: op_q resets to all-ones so a button already held through reset
      // does not look like a fresh press.
      op_q      <= '1;
      cur_x     <= X_W'(INIT_X);
      cur_y     <= Y_W'(INIT_Y);
      eliminate <= 1'b0;
      moved     <= 1'b0;
    end else begin
      op_q      <= operation;
      cur_x     <= nxt_x;
      cur_y     <= nxt_y;
      eliminate <= act_elim;
      moved     <= (nxt_x != cur_x) || (nxt_y != cur_y);
    end
  end

endmodule
